// File: rtl/pe_array_pkg.sv
// Shared widths, FSM encoding and saturation helpers for the PE read-out path.
package pe_array_pkg;

    localparam int DEF_PE_OUTPUT_WD = 18;
    localparam int DEF_OUT_WD       = 8;
    localparam int DEF_SHIFT_WD     = 5;

    localparam logic [0:0] ST_IDLE_CODE = 1'b0;
    localparam logic [0:0] ST_SEND_CODE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = ST_IDLE_CODE,
        ST_SEND = ST_SEND_CODE
    } state_t;

    function automatic int sat_max(input int wd);
        return (1 << (wd - 1)) - 1;
    endfunction

    function automatic int sat_min(input int wd);
        return -(1 << (wd - 1));
    endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: round-half-up, arithmetic right shift, optional ReLU, saturate.
// Optional build macro: PE_DRAIN_RELU_EN clamps negative results to zero.
module pe_requant
    import pe_array_pkg::*;
#(
    parameter int IN_WD    = DEF_PE_OUTPUT_WD,
    parameter int OUT_WD   = DEF_OUT_WD,
    parameter int SHIFT_WD = DEF_SHIFT_WD
) (
    input  logic signed [IN_WD-1:0]  acc,
    input  logic        [SHIFT_WD-1:0] shift,
    output logic signed [OUT_WD-1:0] q
);

    localparam logic signed [IN_WD:0] Q_MAX = (IN_WD+1)'(sat_max(OUT_WD));
    localparam logic signed [IN_WD:0] Q_MIN = (IN_WD+1)'(sat_min(OUT_WD));

    logic signed [IN_WD:0] rnd;
    logic signed [IN_WD:0] t;
    logic signed [IN_WD:0] t_sh;

    always_comb begin
        rnd = '0;
        if (shift != '0 && 32'(shift) < IN_WD)
            rnd = (IN_WD+1)'(1) << (shift - 1'b1);
        t = $signed({acc[IN_WD-1], acc}) + rnd;
        // shifts past the accumulator width collapse to the sign
        if (32'(shift) >= IN_WD)
            t_sh = acc[IN_WD-1] ? '1 : '0;
        else
            t_sh = t >>> shift;
`ifdef PE_DRAIN_RELU_EN
        if (t_sh < 0)
            t_sh = '0;
`endif
        if (t_sh > Q_MAX)
            q = Q_MAX[OUT_WD-1:0];
        else if (t_sh < Q_MIN)
            q = Q_MIN[OUT_WD-1:0];
        else
            q = t_sh[OUT_WD-1:0];
    end

endmodule

// File: rtl/pe_row_drain.sv
// Snapshots one PE row on acc_done_i, clears the PEs and streams requantized results.
// Optional build macro: PE_DRAIN_RELU_EN (ReLU before saturation, protocol unchanged).
//
// state   | meaning
// ST_IDLE | waiting for acc_done_i; snapshot held
// ST_SEND | streaming snap[idx], one element per valid/ready transfer
module pe_row_drain
    import pe_array_pkg::*;
#(
    parameter int PE_NUM       = 16,
    parameter int PE_OUTPUT_WD = DEF_PE_OUTPUT_WD,
    parameter int OUT_WD       = DEF_OUT_WD,
    parameter int SHIFT_WD     = DEF_SHIFT_WD
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           acc_done_i,
    input  logic [PE_NUM*PE_OUTPUT_WD-1:0] pe_acc_i,
    input  logic [SHIFT_WD-1:0]            shift_i,
    output logic                           clr_o,
    output logic                           busy_o,
    output logic                           out_vld_o,
    input  logic                           out_rdy_i,
    output logic [OUT_WD-1:0]              out_data_o,
    output logic [$clog2(PE_NUM)-1:0]      out_idx_o,
    output logic                           out_last_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int                IDX_WD   = $clog2(PE_NUM);
    localparam logic [IDX_WD-1:0] IDX_LAST = IDX_WD'(PE_NUM - 1);

    state_t                          state;
    logic [IDX_WD-1:0]               idx;
    logic signed [PE_OUTPUT_WD-1:0]  snap [PE_NUM];
    logic [SHIFT_WD-1:0]             shift_r;
    logic                            xfer;

    assign xfer = out_vld_o & out_rdy_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            shift_r   <= '0;
            clr_o     <= 1'b0;
            out_vld_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            for (int k = 0; k < PE_NUM; k++)
                snap[k] <= '0;
        end else begin
            clr_o  <= 1'b0;
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (acc_done_i) begin
                        for (int k = 0; k < PE_NUM; k++)
                            snap[k] <= pe_acc_i[k*PE_OUTPUT_WD +: PE_OUTPUT_WD];
                        shift_r   <= shift_i;
                        idx       <= '0;
                        clr_o     <= 1'b1;
                        out_vld_o <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (acc_done_i)
                        err_o <= 1'b1;
                    if (xfer) begin
                        if (idx == IDX_LAST) begin
                            idx       <= '0;
                            out_vld_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign out_idx_o  = idx;
    assign out_last_o = out_vld_o & (idx == IDX_LAST);

    pe_requant #(
        .IN_WD   (PE_OUTPUT_WD),
        .OUT_WD  (OUT_WD),
        .SHIFT_WD(SHIFT_WD)
    ) u_requant (
        .acc  (snap[idx]),
        .shift(shift_r),
        .q    (out_data_o)
    );

endmodule

// File: tb/tb_pe_row_drain.sv
// Directed bench for pe_row_drain: protocol, requant corner cases, backpressure, errors, reset.
module tb_pe_row_drain;

    localparam int PE_NUM = 16;
    localparam int W      = 18;
    localparam int OW     = 8;
    localparam int SW     = 5;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  acc_done_i;
    logic [PE_NUM*W-1:0]   pe_acc_i;
    logic [SW-1:0]         shift_i;
    logic                  clr_o;
    logic                  busy_o;
    logic                  out_vld_o;
    logic                  out_rdy_i;
    logic signed [OW-1:0]  out_data_o;
    logic [3:0]            out_idx_o;
    logic                  out_last_o;
    logic                  done_o;
    logic                  err_o;

    int checks   = 0;
    int failures = 0;

    pe_row_drain #(.PE_NUM(PE_NUM), .PE_OUTPUT_WD(W), .OUT_WD(OW), .SHIFT_WD(SW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .acc_done_i(acc_done_i),
        .pe_acc_i  (pe_acc_i),
        .shift_i   (shift_i),
        .clr_o     (clr_o),
        .busy_o    (busy_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .out_data_o(out_data_o),
        .out_idx_o (out_idx_o),
        .out_last_o(out_last_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input int k, input int v);
        pe_acc_i[k*W +: W] = W'(v);
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < PE_NUM; k++) set_acc(k, v);
    endtask

    function automatic int relu(input int v);
`ifdef PE_DRAIN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        rstn = 1'b0; acc_done_i = 1'b0; out_rdy_i = 1'b0; shift_i = '0; set_all(0);
        tick(); tick();
        checks++; if (out_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", out_vld_o); end
        checks++; if (clr_o !== 1'b0) begin failures++; $display("FAIL reset_clr: got %b expected 0", clr_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL reset_done_err: got %b%b expected 00", done_o, err_o); end
        checks++; if (out_data_o !== 8'sd0 || out_idx_o !== 4'd0 || out_last_o !== 1'b0) begin
            failures++; $display("FAIL reset_data_idx_last: got %0d %0d %b expected 0 0 0", out_data_o, out_idx_o, out_last_o); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_all(300); shift_i = 5'd2; out_rdy_i = 1'b1; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
        for (int i = 0; i < PE_NUM; i++) begin
            checks++; if (out_vld_o !== 1'b1) begin failures++; $display("FAIL basic_vld[%0d]: got %b expected 1", i, out_vld_o); end
            checks++; if (out_idx_o !== 4'(i)) begin failures++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", i, out_idx_o, i); end
            checks++; if (out_data_o !== 8'sd75) begin failures++; $display("FAIL basic_data[%0d]: got %0d expected 75", i, out_data_o); end
            checks++; if (out_last_o !== (i == PE_NUM-1)) begin failures++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_last_o, i == PE_NUM-1); end
            checks++; if (clr_o !== (i == 0)) begin failures++; $display("FAIL basic_clr[%0d]: got %b expected %b", i, clr_o, i == 0); end
            checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_early_done[%0d]: got %b expected 0", i, done_o); end
            tick();
        end
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL basic_done: got %b expected 1", done_o); end
        checks++; if (out_vld_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL basic_idle: got vld=%b busy=%b expected 0 0", out_vld_o, busy_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", done_o); end
    endtask

    task automatic test_requant();
        int acc_t [4][16];
        int exp_t [4][16];
        int sh_t  [4];
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 16; k++) begin acc_t[d][k] = 0; exp_t[d][k] = 0; end
        sh_t[0] = 2;
        acc_t[0][0] = -300;  exp_t[0][0] = -75;
        acc_t[0][1] = 6;     exp_t[0][1] = 2;
        acc_t[0][2] = 5;     exp_t[0][2] = 1;
        acc_t[0][3] = -6;    exp_t[0][3] = -1;
        acc_t[0][4] = -7;    exp_t[0][4] = -2;
        acc_t[0][5] = 1000;  exp_t[0][5] = 127;
        acc_t[0][6] = 300;   exp_t[0][6] = 75;
        acc_t[0][7] = -1000; exp_t[0][7] = -128;
        sh_t[1] = 0;
        acc_t[1][0] = 40000;  exp_t[1][0] = 127;
        acc_t[1][1] = -40000; exp_t[1][1] = -128;
        acc_t[1][2] = 127;    exp_t[1][2] = 127;
        acc_t[1][3] = -128;   exp_t[1][3] = -128;
        acc_t[1][4] = 128;    exp_t[1][4] = 127;
        acc_t[1][5] = -129;   exp_t[1][5] = -128;
        sh_t[2] = 20;
        acc_t[2][0] = 100;     exp_t[2][0] = 0;
        acc_t[2][1] = -100;    exp_t[2][1] = -1;
        acc_t[2][2] = 131071;  exp_t[2][2] = 0;
        acc_t[2][3] = -131072; exp_t[2][3] = -1;
        sh_t[3] = 17;
        acc_t[3][0] = 131071;  exp_t[3][0] = 1;
        acc_t[3][1] = -131072; exp_t[3][1] = -1;
        acc_t[3][2] = 65535;   exp_t[3][2] = 0;
        acc_t[3][3] = -65536;  exp_t[3][3] = 0;
        out_rdy_i = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 16; k++) set_acc(k, acc_t[d][k]);
            shift_i = SW'(sh_t[d]);
            acc_done_i = 1'b1;
            tick();
            acc_done_i = 1'b0;
            for (int i = 0; i < PE_NUM; i++) begin
                checks++; if (out_vld_o !== 1'b1 || out_idx_o !== 4'(i) || $signed(out_data_o) !== relu(exp_t[d][i])) begin
                    failures++; $display("FAIL requant[%0d][%0d]: got vld=%b idx=%0d data=%0d expected 1 %0d %0d",
                                         d, i, out_vld_o, out_idx_o, out_data_o, i, relu(exp_t[d][i])); end
                tick();
            end
            checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL requant_done[%0d]: got %b expected 1", d, done_o); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic stalled = 1'b0;
        logic signed [OW-1:0] pd = '0;
        logic [3:0] pi = '0;
        for (int k = 0; k < 16; k++) set_acc(k, 3*k - 20);
        shift_i = 5'd0; out_rdy_i = 1'b0; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        for (int cyc = 0; cyc < 400 && n < PE_NUM; cyc++) begin
            if (stalled) begin
                checks++; if (out_data_o !== pd || out_idx_o !== pi) begin
                    failures++; $display("FAIL bp_stable: got data=%0d idx=%0d expected %0d %0d", out_data_o, out_idx_o, pd, pi); end
            end
            checks++; if (out_vld_o !== 1'b1) begin failures++; $display("FAIL bp_vld[%0d]: got %b expected 1", n, out_vld_o); end
            out_rdy_i = 1'($urandom_range(0, 1));
            if (out_rdy_i) begin
                checks++; if (out_idx_o !== 4'(n) || $signed(out_data_o) !== relu(3*n - 20)) begin
                    failures++; $display("FAIL bp_xfer[%0d]: got idx=%0d data=%0d expected %0d %0d", n, out_idx_o, out_data_o, n, relu(3*n - 20)); end
                n++;
            end
            stalled = ~out_rdy_i;
            pd = out_data_o;
            pi = out_idx_o;
            tick();
        end
        out_rdy_i = 1'b0;
        checks++; if (n !== PE_NUM) begin failures++; $display("FAIL bp_count: got %0d expected %0d", n, PE_NUM); end
        checks++; if (done_o !== 1'b1 || out_vld_o !== 1'b0) begin failures++; $display("FAIL bp_done: got done=%b vld=%b expected 1 0", done_o, out_vld_o); end
        tick();
        checks++; if (out_vld_o !== 1'b0) begin failures++; $display("FAIL bp_no_extra: got vld=%b expected 0", out_vld_o); end
    endtask

    task automatic test_snapshot();
        set_all(400); shift_i = 5'd2; out_rdy_i = 1'b1; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        set_all(-1000); shift_i = 5'd0;
        for (int i = 0; i < PE_NUM; i++) begin
            checks++; if (out_data_o !== 8'sd100 || out_idx_o !== 4'(i)) begin
                failures++; $display("FAIL snapshot[%0d]: got data=%0d idx=%0d expected 100 %0d", i, out_data_o, out_idx_o, i); end
            tick();
        end
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL snapshot_done: got %b expected 1", done_o); end
        tick();
    endtask

    task automatic test_busy_err();
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_initial: got %b expected 0", err_o); end
        set_all(8); shift_i = 5'd1; out_rdy_i = 1'b1; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        for (int i = 0; i < PE_NUM; i++) begin
            checks++; if (out_data_o !== 8'sd4 || out_idx_o !== 4'(i) || clr_o !== (i == 0)) begin
                failures++; $display("FAIL busy_stream[%0d]: got data=%0d idx=%0d clr=%b expected 4 %0d %b", i, out_data_o, out_idx_o, clr_o, i, i == 0); end
            checks++; if (err_o !== (i >= 8)) begin failures++; $display("FAIL busy_err[%0d]: got %b expected %b", i, err_o, i >= 8); end
            acc_done_i = (i == 7 || i == 15);
            if (i == 7) begin set_all(100); shift_i = 5'd0; end
            tick();
        end
        acc_done_i = 1'b0;
        checks++; if (done_o !== 1'b1 || out_vld_o !== 1'b0 || clr_o !== 1'b0 || err_o !== 1'b1) begin
            failures++; $display("FAIL busy_last_ignored: got done=%b vld=%b clr=%b err=%b expected 1 0 0 1", done_o, out_vld_o, clr_o, err_o); end
        set_all(12); shift_i = 5'd2; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        checks++; if (out_vld_o !== 1'b1 || clr_o !== 1'b1 || out_idx_o !== 4'd0 || out_data_o !== 8'sd3) begin
            failures++; $display("FAIL done_cycle_start: got vld=%b clr=%b idx=%0d data=%0d expected 1 1 0 3", out_vld_o, clr_o, out_idx_o, out_data_o); end
        for (int i = 0; i < PE_NUM; i++) begin
            checks++; if (out_data_o !== 8'sd3 || out_idx_o !== 4'(i)) begin
                failures++; $display("FAIL second_drain[%0d]: got data=%0d idx=%0d expected 3 %0d", i, out_data_o, out_idx_o, i); end
            tick();
        end
        checks++; if (done_o !== 1'b1 || err_o !== 1'b1) begin failures++; $display("FAIL second_done: got done=%b err=%b expected 1 1", done_o, err_o); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        set_all(300); shift_i = 5'd2; out_rdy_i = 1'b1; acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (out_idx_o !== 4'd5) begin failures++; $display("FAIL mid_idx: got %0d expected 5", out_idx_o); end
        rstn = 1'b0;
        #1;
        checks++; if (out_vld_o !== 1'b0 || busy_o !== 1'b0 || clr_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_ctrl: got vld=%b busy=%b clr=%b done=%b err=%b expected all 0", out_vld_o, busy_o, clr_o, done_o, err_o); end
        checks++; if (out_idx_o !== 4'd0 || out_data_o !== 8'sd0 || out_last_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_data: got idx=%0d data=%0d last=%b expected 0 0 0", out_idx_o, out_data_o, out_last_o); end
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (done_o !== 1'b0 || out_vld_o !== 1'b0) begin failures++; $display("FAIL mid_no_done: got done=%b vld=%b expected 0 0", done_o, out_vld_o); end
        acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        for (int i = 0; i < PE_NUM; i++) begin
            checks++; if (out_data_o !== 8'sd75 || out_idx_o !== 4'(i) || out_vld_o !== 1'b1) begin
                failures++; $display("FAIL post_reset[%0d]: got vld=%b data=%0d idx=%0d expected 1 75 %0d", i, out_vld_o, out_data_o, out_idx_o, i); end
            tick();
        end
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL post_reset_done: got %b expected 1", done_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_requant();
        test_backpressure();
        test_snapshot();
        test_busy_err();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
